// File: rtl/spi_pkg.sv
`default_nettype none
// spi_pkg - shared SPI mode decode, idle-fill byte and slave state encoding.
// Rev 1.0
package spi_pkg;

    localparam logic [7:0] IDLE_FILL = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic mode_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input int mode);
        return mode[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// spi_sync_edge - 3-flop synchronizer; the third flop yields rise/fall pulses.
// Rev 1.0
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// spi_slave - oversampled SPI slave (modes 0..3) with a one-byte TX holding buffer.
// Rev 1.0
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    localparam logic CPOL = mode_cpol(SPI_MODE);
    localparam logic CPHA = mode_cpha(SPI_MODE);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic       r_mosi_meta, r_mosi_sync;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [7:0] r_tx_shift;
    logic       r_miso;
    logic       r_first;
    logic [7:0] r_hold;
    logic       r_hold_full;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .i_async (sck),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_async (cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Two stages only, so the sampled bit lines up with the sck edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    logic       w_lead, w_trail, w_enter, w_run, w_sample, w_wrap;
    logic       w_load_out, w_load_only, w_shift, w_xfer;
    logic [7:0] w_fill;

    assign w_lead      = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail     = CPOL ? w_sck_rise : w_sck_fall;
    assign w_enter     = (r_state == ST_IDLE) && w_cs_fall;
    assign w_run       = (r_state == ST_ACTIVE) && !w_cs_rise;
    assign w_sample    = w_run && (CPHA ? w_trail : w_lead);
    assign w_wrap      = w_sample && (r_bit_cnt == 3'd7);
    // CPHA=0 wraps on a sample edge, so the next byte is loaded without being
    // shown; the following trailing edge then presents its MSB.
    assign w_load_out  = CPHA ? (w_run && w_lead && r_first) : w_enter;
    assign w_load_only = !CPHA && w_wrap;
    assign w_shift     = w_run && (CPHA ? w_lead : w_trail) && !w_load_out;
    assign w_xfer      = w_load_out || w_load_only;
    assign w_fill      = r_hold_full ? r_hold : IDLE_FILL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_shift  <= 8'h00;
            r_miso      <= 1'b0;
            r_first     <= 1'b0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_enter) begin
                r_bit_cnt <= 3'd0;
                r_first   <= 1'b1;
            end else if (w_sample) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_rx_shift <= {r_rx_shift[6:0], r_mosi_sync};
                if (w_wrap) begin
                    r_rx_data  <= {r_rx_shift[6:0], r_mosi_sync};
                    r_rx_valid <= 1'b1;
                    r_first    <= 1'b1;
                end
            end

            if (w_load_out) begin
                r_miso     <= w_fill[7];
                r_tx_shift <= {w_fill[6:0], 1'b0};
                r_first    <= 1'b0;
            end else if (w_load_only) begin
                r_tx_shift <= w_fill;
            end else if (w_shift) begin
                r_miso     <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            if (w_xfer) begin
                r_hold_full <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // A byte arriving in the same cycle as a transfer waits one clk.
    assign tx_ready = !r_hold_full && !w_xfer;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign miso_oe  = (r_state == ST_ACTIVE);
    assign miso     = (r_state == ST_ACTIVE) && r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
`timescale 1ns/1ps
// tb_spi_slave - directed bench for spi_slave, one instance per SPI mode.
// Rev 1.0
module tb_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sck, cs_n, mosi, tx_valid, tx_ready, rx_valid, miso, miso_oe;
    logic [7:0] tx_data [4];
    logic [7:0] rx_data [4];
    int         errors = 0;
    int         checks = 0;
    int         rxcnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            spi_slave #(.SPI_MODE(g)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .tx_data  (tx_data[g]),
                .tx_valid (tx_valid[g]),
                .tx_ready (tx_ready[g]),
                .rx_data  (rx_data[g]),
                .rx_valid (rx_valid[g]),
                .sck      (sck[g]),
                .cs_n     (cs_n[g]),
                .mosi     (mosi[g]),
                .miso     (miso[g]),
                .miso_oe  (miso_oe[g])
            );
        end
    endgenerate

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (rx_valid[k] === 1'b1) rxcnt[k]++;
    end

    function automatic logic cpol_of(input int m);
        return ((m >> 1) & 1) != 0;
    endfunction

    function automatic logic cpha_of(input int m);
        return (m & 1) != 0;
    endfunction

    task automatic load_tx(input int m, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (tx_ready[m] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL tx_ready_wait m%0d: got %b expected 1", m, tx_ready[m]);
        end
        tx_data[m]  = b;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        checks++;
        if (tx_ready[m] !== 1'b0) begin
            errors++;
            $display("FAIL tx_ready_low m%0d: got %b expected 0", m, tx_ready[m]);
        end
    endtask

    task automatic cs_low(input int m);
        sck[m]  = cpol_of(m);
        cs_n[m] = 1'b0;
        repeat (H) @(negedge clk);
        checks++;
        if (miso_oe[m] !== 1'b1) begin
            errors++;
            $display("FAIL miso_oe_active m%0d: got %b expected 1", m, miso_oe[m]);
        end
    endtask

    task automatic cs_high(input int m);
        repeat (4) @(negedge clk);
        cs_n[m] = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_byte(input int m, input logic [7:0] d, input int nbits,
                            output logic [7:0] q);
        logic pol;
        pol = cpol_of(m);
        q = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_of(m)) begin
                mosi[m] = d[7-i];
                repeat (H) @(negedge clk);
                q[7-i] = miso[m];
                sck[m] = ~pol;
                repeat (H) @(negedge clk);
                sck[m] = pol;
            end else begin
                sck[m]  = ~pol;
                mosi[m] = d[7-i];
                repeat (H) @(negedge clk);
                q[7-i] = miso[m];
                sck[m] = pol;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks += 5;
            if (tx_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready m%0d: got %b expected 1", k, tx_ready[k]); end
            if (rx_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid m%0d: got %b expected 0", k, rx_valid[k]); end
            if (rx_data[k] !== 8'h00) begin errors++; $display("FAIL reset_rx_data m%0d: got %h expected 00", k, rx_data[k]); end
            if (miso[k] !== 1'b0) begin errors++; $display("FAIL reset_miso m%0d: got %b expected 0", k, miso[k]); end
            if (miso_oe[k] !== 1'b0) begin errors++; $display("FAIL reset_miso_oe m%0d: got %b expected 0", k, miso_oe[k]); end
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mode(input int m, input logic [7:0] txb, input logic [7:0] rxb);
        logic [7:0] q;
        int base;
        base = rxcnt[m];
        load_tx(m, txb);
        cs_low(m);
        spi_byte(m, rxb, 8, q);
        cs_high(m);
        checks += 3;
        if (q !== txb) begin errors++; $display("FAIL mode%0d_miso: got %h expected %h", m, q, txb); end
        if (rx_data[m] !== rxb) begin errors++; $display("FAIL mode%0d_rx_data: got %h expected %h", m, rx_data[m], rxb); end
        if (rxcnt[m] - base != 1) begin errors++; $display("FAIL mode%0d_rx_pulses: got %0d expected 1", m, rxcnt[m] - base); end
    endtask

    task automatic test_burst();
        logic [7:0] q0, q1, q2;
        int base;
        base = rxcnt[0];
        load_tx(0, 8'h11);
        cs_low(0);
        load_tx(0, 8'h22);
        spi_byte(0, 8'hA1, 8, q0);
        checks++;
        if (rx_data[0] !== 8'hA1) begin errors++; $display("FAIL burst_rx0: got %h expected a1", rx_data[0]); end
        load_tx(0, 8'h33);
        spi_byte(0, 8'hB2, 8, q1);
        checks++;
        if (rx_data[0] !== 8'hB2) begin errors++; $display("FAIL burst_rx1: got %h expected b2", rx_data[0]); end
        spi_byte(0, 8'hC4, 8, q2);
        cs_high(0);
        checks += 5;
        if (rx_data[0] !== 8'hC4) begin errors++; $display("FAIL burst_rx2: got %h expected c4", rx_data[0]); end
        if (q0 !== 8'h11) begin errors++; $display("FAIL burst_miso0: got %h expected 11", q0); end
        if (q1 !== 8'h22) begin errors++; $display("FAIL burst_miso1: got %h expected 22", q1); end
        if (q2 !== 8'h33) begin errors++; $display("FAIL burst_miso2: got %h expected 33", q2); end
        if (rxcnt[0] - base != 3) begin errors++; $display("FAIL burst_rx_pulses: got %0d expected 3", rxcnt[0] - base); end
    endtask

    task automatic test_underrun();
        logic [7:0] q;
        cs_low(0);
        spi_byte(0, 8'h00, 8, q);
        cs_high(0);
        checks += 2;
        if (q !== 8'hFF) begin errors++; $display("FAIL underrun_miso: got %h expected ff", q); end
        if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL underrun_rx: got %h expected 00", rx_data[0]); end
    endtask

    task automatic test_abort();
        logic [7:0] q;
        int base;
        base = rxcnt[0];
        cs_low(0);
        load_tx(0, 8'h9C);
        spi_byte(0, 8'hAA, 5, q);
        cs_high(0);
        checks += 3;
        if (rxcnt[0] - base != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d expected 0", rxcnt[0] - base); end
        if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL abort_rx_hold: got %h expected 00", rx_data[0]); end
        if (miso_oe[0] !== 1'b0) begin errors++; $display("FAIL abort_miso_oe: got %b expected 0", miso_oe[0]); end
        cs_low(0);
        spi_byte(0, 8'h55, 8, q);
        cs_high(0);
        checks += 3;
        if (rx_data[0] !== 8'h55) begin errors++; $display("FAIL abort_next_rx: got %h expected 55", rx_data[0]); end
        if (rxcnt[0] - base != 1) begin errors++; $display("FAIL abort_next_pulses: got %0d expected 1", rxcnt[0] - base); end
        if (q !== 8'h9C) begin errors++; $display("FAIL abort_hold_kept: got %h expected 9c", q); end
    endtask

    task automatic test_async_reset();
        logic [7:0] q;
        int base;
        base = rxcnt[0];
        cs_low(0);
        load_tx(0, 8'h66);
        spi_byte(0, 8'h0F, 3, q);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL arst_tx_ready: got %b expected 1", tx_ready[0]); end
        if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL arst_rx_valid: got %b expected 0", rx_valid[0]); end
        if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL arst_rx_data: got %h expected 00", rx_data[0]); end
        if (miso[0] !== 1'b0) begin errors++; $display("FAIL arst_miso: got %b expected 0", miso[0]); end
        if (miso_oe[0] !== 1'b0) begin errors++; $display("FAIL arst_miso_oe: got %b expected 0", miso_oe[0]); end
        cs_n[0] = 1'b1;
        sck[0]  = cpol_of(0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        cs_low(0);
        spi_byte(0, 8'hC3, 8, q);
        cs_high(0);
        checks += 3;
        if (rx_data[0] !== 8'hC3) begin errors++; $display("FAIL arst_next_rx: got %h expected c3", rx_data[0]); end
        if (rxcnt[0] - base != 1) begin errors++; $display("FAIL arst_rx_pulses: got %0d expected 1", rxcnt[0] - base); end
        if (q !== 8'hFF) begin errors++; $display("FAIL arst_hold_cleared: got %h expected ff", q); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            sck[k]      = cpol_of(k);
            cs_n[k]     = 1'b1;
            mosi[k]     = 1'b0;
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        test_reset();
        test_mode(0, 8'hA5, 8'h3C);
        test_mode(1, 8'h7E, 8'h81);
        test_mode(2, 8'h7E, 8'h81);
        test_mode(3, 8'h7E, 8'h81);
        test_burst();
        test_underrun();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
